// File: rtl/alu_pkg.sv
// Opcode encoding shared by the issuer and the registered ALU, plus a
// wide signed reference model of the ALU arithmetic (callers truncate to their width).
package alu_pkg;

  localparam int OPS     = 4;
  localparam int MODEL_W = 64;

  typedef enum logic [1:0] {
    ALU_ADD     = 2'd0,
    ALU_A_SUB_B = 2'd1,
    ALU_B_SUB_A = 2'd2,
    ALU_MULT    = 2'd3
  } alu_op_e;

  function automatic logic signed [MODEL_W-1:0] alu_model(
    input alu_op_e                    op,
    input logic signed [MODEL_W-1:0]  a,
    input logic signed [MODEL_W-1:0]  b
  );
    logic signed [MODEL_W-1:0] r;
    case (op)
      ALU_ADD:     r = a + b;
      ALU_A_SUB_B: r = a - b;
      ALU_B_SUB_A: r = b - a;
      default:     r = a * b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Show-ahead response FIFO: head visible the cycle after the write, reads as 0 when empty.
// Writes while full are dropped unless a pop coincides; upstream credit keeps that from happening.
module alu_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_data,
  input  logic                         rd_en,
  output logic [W-1:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_rd, do_wr;

  assign do_rd = rd_en && (cnt_q != '0);
  assign do_wr = wr_en && ((cnt_q != CW'(DEPTH)) || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_wr) - CW'(do_rd);
    end
  end

  // Gate the head so an empty (or freshly reset) FIFO presents zeros, not stale storage.
  assign rd_data = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count   = cnt_q;

endmodule

// File: rtl/alu_req_issuer.sv
// Issues tagged commands to a fixed-latency ALU and queues results in order; response at head ALU_LAT+1 cycles after accept.
// cmd_ready only when in-flight plus queued results fit the FIFO; optional result checker under ALU_REQ_ISSUER_CHECK_EN.
module alu_req_issuer #(
  parameter int DATAW     = 16,
  parameter int OPS       = 4,
  parameter int OPCODEW   = $clog2(OPS),
  parameter int TAGW      = 4,
  parameter int ALU_LAT   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OPCODEW-1:0] cmd_opcode,
  input  logic [DATAW-1:0]   cmd_dataa,
  input  logic [DATAW-1:0]   cmd_datab,
  input  logic [TAGW-1:0]    cmd_tag,
  output logic [OPCODEW-1:0] alu_opcode,
  output logic [DATAW-1:0]   alu_dataa,
  output logic [DATAW-1:0]   alu_datab,
  input  logic [DATAW-1:0]   alu_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATAW-1:0]   rsp_result,
  output logic [TAGW-1:0]    rsp_tag,
`ifdef ALU_REQ_ISSUER_CHECK_EN
  output logic               rsp_mismatch,
`endif
  output logic               busy
);

  import alu_pkg::*;

  // Stage 0 lines up with the alu_* registers; the last stage lines up with alu_result.
  localparam int STAGES = ALU_LAT + 1;
  localparam int CNTW   = $clog2(RSP_DEPTH + 1);
  localparam int SUMW   = $clog2(STAGES + RSP_DEPTH + 2) + 1;
`ifdef ALU_REQ_ISSUER_CHECK_EN
  localparam int FW = 1 + TAGW + DATAW;
`else
  localparam int FW = TAGW + DATAW;
`endif

  logic               ready_en_q;
  logic [OPCODEW-1:0] opcode_q;
  logic [DATAW-1:0]   dataa_q, datab_q;
  logic [STAGES-1:0]  pv_q, pv_d;
  logic [TAGW-1:0]    ptag_q [STAGES];
  logic [SUMW-1:0]    inflight;
  logic [CNTW-1:0]    occ;
  logic               accept, pop, cap;
  logic [FW-1:0]      cap_dat, head_dat;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++) inflight = inflight + SUMW'(pv_q[i]);
  end

  // A pop this cycle frees a slot, so it is credited back combinationally.
  assign pop       = rsp_valid & rsp_ready;
  assign cmd_ready = ready_en_q &&
                     ((inflight + SUMW'(occ)) < (SUMW'(RSP_DEPTH) + SUMW'(pop)));
  assign accept    = cmd_valid & cmd_ready;
  assign cap       = pv_q[STAGES-1];
  assign pv_d      = {pv_q[STAGES-2:0], accept};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      opcode_q   <= '0;
      dataa_q    <= '0;
      datab_q    <= '0;
      pv_q       <= '0;
      for (int i = 0; i < STAGES; i++) ptag_q[i] <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) begin
        opcode_q <= cmd_opcode;
        dataa_q  <= cmd_dataa;
        datab_q  <= cmd_datab;
      end
      pv_q      <= pv_d;
      ptag_q[0] <= cmd_tag;
      for (int i = 1; i < STAGES; i++) ptag_q[i] <= ptag_q[i-1];
    end
  end

`ifdef ALU_REQ_ISSUER_CHECK_EN
  logic [DATAW-1:0] pexp_q [STAGES];
  logic [DATAW-1:0] exp_d;

  assign exp_d = DATAW'(alu_model(alu_op_e'(cmd_opcode),
                                  MODEL_W'(signed'(cmd_dataa)),
                                  MODEL_W'(signed'(cmd_datab))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) pexp_q[i] <= '0;
    end else begin
      pexp_q[0] <= exp_d;
      for (int i = 1; i < STAGES; i++) pexp_q[i] <= pexp_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && cap) assert (alu_result == pexp_q[STAGES-1]);
  end

  assign cap_dat = {alu_result != pexp_q[STAGES-1], ptag_q[STAGES-1], alu_result};
  assign {rsp_mismatch, rsp_tag, rsp_result} = head_dat;
`else
  assign cap_dat = {ptag_q[STAGES-1], alu_result};
  assign {rsp_tag, rsp_result} = head_dat;
`endif

  alu_rsp_fifo #(
    .W     (FW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cap),
    .wr_data (cap_dat),
    .rd_en   (pop),
    .rd_data (head_dat),
    .count   (occ)
  );

  assign alu_opcode = opcode_q;
  assign alu_dataa  = dataa_q;
  assign alu_datab  = datab_q;
  assign rsp_valid  = (occ != '0);
  assign busy       = (inflight != '0) || (occ != '0);

endmodule

// File: tb/tb_alu_req_issuer.sv
// Directed bench for alu_req_issuer with a 2-stage registered ALU model and an in-order scoreboard.
module tb_alu_req_issuer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_opcode;
  logic [15:0] cmd_dataa, cmd_datab;
  logic [3:0]  cmd_tag;
  logic [1:0]  alu_opcode;
  logic [15:0] alu_dataa, alu_datab, alu_result;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        busy;
`ifdef ALU_REQ_ISSUER_CHECK_EN
  logic        rsp_mismatch;
`endif

  int checks   = 0;
  int failures = 0;
  int outstanding = 0;
  logic err_mode;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  tag;
    logic        mm;
  } sb_t;
  sb_t sb [$];

  alu_req_issuer #(
    .DATAW(16), .OPS(4), .OPCODEW(2), .TAGW(4), .ALU_LAT(2), .RSP_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_dataa  (cmd_dataa),
    .cmd_datab  (cmd_datab),
    .cmd_tag    (cmd_tag),
    .alu_opcode (alu_opcode),
    .alu_dataa  (alu_dataa),
    .alu_datab  (alu_datab),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
`ifdef ALU_REQ_ISSUER_CHECK_EN
    .rsp_mismatch (rsp_mismatch),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = b - a;
      default: r = a * b;
    endcase
    return r;
  endfunction

  // Registered ALU, ALU_LAT=2; operand 0x0BAD is corrupted by +1 when err_mode is set.
  logic [15:0] alu_s1, alu_s2;
  always @(posedge clk) begin
    alu_s1 <= ref_alu(alu_opcode, alu_dataa, alu_datab) +
              16'((err_mode && alu_dataa == 16'h0BAD) ? 1 : 0);
    alu_s2 <= alu_s1;
  end
  assign alu_result = alu_s2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
    int n = 0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_dataa = a; cmd_datab = b; cmd_tag = tag;
    #0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("issue_wait_bound", 32'(n < 50), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Scoreboard sampled mid-cycle: handshakes here take effect on the following edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      outstanding = 0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("sb_spurious_rsp", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("sb_result", 32'(rsp_result), 32'(e.res));
          check("sb_tag", 32'(rsp_tag), 32'(e.tag));
`ifdef ALU_REQ_ISSUER_CHECK_EN
          check("sb_mismatch", 32'(rsp_mismatch), 32'(e.mm));
`endif
          outstanding--;
        end
      end
      if (cmd_valid && cmd_ready) begin
        sb_t n;
        n.mm  = err_mode && (cmd_dataa == 16'h0BAD);
        n.res = ref_alu(cmd_opcode, cmd_dataa, cmd_datab) + 16'(n.mm);
        n.tag = cmd_tag;
        sb.push_back(n);
        outstanding++;
      end
      check("credit_invariant", 32'(outstanding <= 4), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_r [4];
    int k;
    int n;
    exp_r[0] = 16'd3; exp_r[1] = 16'd6; exp_r[2] = 16'hFFFA; exp_r[3] = 16'h5F90;
    err_mode = 1'b0;

    // Reset with a command already waiting.
    rst_n = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_opcode = 2'd0; cmd_dataa = 16'd5; cmd_datab = 16'hFFFD; cmd_tag = 4'd7;
    tick(); tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_alu_dataa", 32'(alu_dataa), 32'd0);
    check("rst_alu_datab", 32'(alu_datab), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
`ifdef ALU_REQ_ISSUER_CHECK_EN
    check("rst_rsp_mismatch", 32'(rsp_mismatch), 32'd0);
`endif
    rst_n = 1'b1; #1;
    check("release_cycle_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("first_cycle_ready", 32'(cmd_ready), 32'd1);
    check("no_accept_during_release", 32'(alu_dataa), 32'd0);

    // Single add 5 + -3, tag 7.
    tick();
    cmd_valid = 1'b0;
    check("add_alu_opcode", 32'(alu_opcode), 32'd0);
    check("add_alu_dataa", 32'(alu_dataa), 32'd5);
    check("add_alu_datab", 32'(alu_datab), 32'hFFFD);
    check("add_busy", 32'(busy), 32'd1);
    check("add_rsp_e0", 32'(rsp_valid), 32'd0);
    tick(); check("add_rsp_e1", 32'(rsp_valid), 32'd0);
    tick(); check("add_rsp_e2", 32'(rsp_valid), 32'd0);
    tick();
    check("add_rsp_e3_valid", 32'(rsp_valid), 32'd1);
    check("add_rsp_result", 32'(rsp_result), 32'd2);
    check("add_rsp_tag", 32'(rsp_tag), 32'd7);
    tick();
    check("add_rsp_one_cycle", 32'(rsp_valid), 32'd0);
    check("add_idle", 32'(busy), 32'd0);

    // Four back-to-back ops with the response side stalled.
    rsp_ready = 1'b0;
    issue(2'd0, 16'd1, 16'd2, 4'd1);
    issue(2'd1, 16'd10, 16'd4, 4'd2);
    issue(2'd2, 16'd10, 16'd4, 4'd3);
    issue(2'd3, 16'd300, 16'd300, 4'd4);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1; cmd_opcode = 2'd0; cmd_dataa = 16'd7; cmd_datab = 16'd8; cmd_tag = 4'd5;
    repeat (6) tick();
    check("full_hold_ready", 32'(cmd_ready), 32'd0);
    check("full_alu_hold", 32'(alu_dataa), 32'd300);
    rsp_ready = 1'b1; #1;
    check("credit_on_pop", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("b2b_head_valid", 32'(rsp_valid), 32'd1);
      check("b2b_head_result", 32'(rsp_result), 32'(exp_r[i]));
      check("b2b_head_tag", 32'(rsp_tag), 32'(i + 1));
      tick();
      if (i == 0) cmd_valid = 1'b0;
    end
    check("refill_valid", 32'(rsp_valid), 32'd1);
    check("refill_result", 32'(rsp_result), 32'd15);
    check("refill_tag", 32'(rsp_tag), 32'd5);
    tick();
    check("refill_drained", 32'(busy), 32'd0);

    // Full FIFO, then continuous commands: one accept per pop.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(2'd0, 16'(i * 100), 16'd1, 4'(i));
    repeat (4) tick();
    rsp_ready = 1'b1;
    k = 0;
    cmd_valid = 1'b1; cmd_opcode = 2'd0; cmd_dataa = 16'd1; cmd_datab = 16'd2; cmd_tag = 4'd0;
    #1;
    for (int c = 0; c < 24; c++) begin
      if (cmd_ready) begin
        tick();
        k++;
        cmd_opcode = 2'(k); cmd_dataa = 16'(k * 3 + 1); cmd_datab = 16'(k + 2); cmd_tag = 4'(k);
      end else begin
        tick();
      end
    end
    cmd_valid = 1'b0;
    check("steady_accepts", 32'(k), 32'd24);
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("drain_idle", 32'(busy), 32'd0);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Reset with one queued and two in flight.
    rsp_ready = 1'b0;
    issue(2'd0, 16'd11, 16'd22, 4'hA);
    repeat (4) tick();
    check("mid_queued", 32'(rsp_valid), 32'd1);
    issue(2'd1, 16'd40, 16'd2, 4'hB);
    issue(2'd3, 16'd6, 16'd7, 4'hC);
    rst_n = 1'b0; #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    tick(); tick();
    rst_n = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end

`ifdef ALU_REQ_ISSUER_CHECK_EN
    err_mode = 1'b1;
    rsp_ready = 1'b0;
    issue(2'd0, 16'd1, 16'd1, 4'd1);
    issue(2'd0, 16'h0BAD, 16'd1, 4'd2);
    issue(2'd0, 16'd3, 16'd1, 4'd3);
    repeat (6) tick();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("chk_mismatch", 32'(rsp_mismatch), 32'(i == 1));
      tick();
    end
    err_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
